// File: rtl/data_bus_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// data_bus_arbiter_pkg
//  Shared definitions for the data-bus arbiter: FSM state encoding, grant
//  codes, internal counter widths and a helper that maps a state to its
//  grant code.
// ----------------------------------------------------------------------------
package data_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACC_CORE = 2'd1,
        ACC_LDR  = 2'd2
    } arb_state_e;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_CORE = 2'b01;
    localparam logic [1:0] GNT_LDR  = 2'b10;

    // Wide enough for MAX_WAIT up to 15 and TIMEOUT up to 255
    localparam int STARVE_W = 4;
    localparam int TMO_W    = 8;

    // Grant code that accompanies a given FSM state
    function automatic logic [1:0] state_to_grant(input arb_state_e s);
        logic [1:0] g;
        case (s)
            ACC_CORE: g = GNT_CORE;
            ACC_LDR:  g = GNT_LDR;
            default:  g = GNT_NONE;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/data_bus_arbiter_arb_timer.sv
// ----------------------------------------------------------------------------
// arb_timer
//  Saturating up-counter with synchronous clear. Clear has priority over
//  increment; the count stops at LIMIT.
//  Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   i_clr       synchronous clear
//   i_inc       increment request (ignored once LIMIT is reached)
//   o_cnt       current count
// ----------------------------------------------------------------------------
module arb_timer #(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] LIMIT = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_cnt
);

    // Counter register: clear, saturating increment, or hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_cnt <= {WIDTH{1'b0}};
        end else if (i_clr) begin
            o_cnt <= {WIDTH{1'b0}};
        end else if (i_inc && (o_cnt != LIMIT)) begin
            o_cnt <= o_cnt + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            o_cnt <= o_cnt;
        end
    end

endmodule

// File: rtl/data_bus_arbiter.sv
// ----------------------------------------------------------------------------
// data_bus_arbiter
//  Shares the data-memory bus between the core MEM stage and the UART program
//  loader. The core has fixed priority, but once the loader has lost MAX_WAIT
//  consecutive arbitrations it is forced to win. Grant is registered; each
//  access waits for bus_ready and is aborted with bus_err after TIMEOUT cycles.
//  Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   core_req/we/addr/wd, core_rd     core request side and read data
//   core_ready, core_stall           completion pulse, stall to hazard logic
//   ldr_req/we/addr/wd, ldr_rd       loader request side and read data
//   ldr_ready                        loader completion pulse
//   bus_we/re/addr/wd, bus_rd        memory-map bus
//   bus_ready                        slave completes access this cycle
//   grant                            01=core, 10=loader, 00=idle (registered)
//   bus_err                          pulse on timeout abort
// ----------------------------------------------------------------------------
module data_bus_arbiter
    import data_bus_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MAX_WAIT   = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  core_req,
    input  logic                  core_we,
    input  logic [ADDR_WIDTH-1:0] core_addr,
    input  logic [DATA_WIDTH-1:0] core_wd,
    output logic [DATA_WIDTH-1:0] core_rd,
    output logic                  core_ready,
    output logic                  core_stall,
    input  logic                  ldr_req,
    input  logic                  ldr_we,
    input  logic [ADDR_WIDTH-1:0] ldr_addr,
    input  logic [DATA_WIDTH-1:0] ldr_wd,
    output logic [DATA_WIDTH-1:0] ldr_rd,
    output logic                  ldr_ready,
    output logic                  bus_we,
    output logic                  bus_re,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [DATA_WIDTH-1:0] bus_wd,
    input  logic [DATA_WIDTH-1:0] bus_rd,
    input  logic                  bus_ready,
    output logic [1:0]            grant,
    output logic                  bus_err
);

    localparam logic [STARVE_W-1:0] L_MAX_WAIT = STARVE_W'(MAX_WAIT);
    localparam logic [TMO_W-1:0]    L_TMO_LIM  = TMO_W'(TIMEOUT);
    localparam logic [TMO_W-1:0]    L_TMO_LAST = TMO_W'(TIMEOUT - 1);

    arb_state_e          r_state;
    logic [1:0]          r_grant;
    logic [STARVE_W-1:0] w_starve_cnt;
    logic [TMO_W-1:0]    w_tmo_cnt;

    logic w_idle;
    logic w_core_win;
    logic w_ldr_win;
    logic w_tmo_hit;
    logic w_done;

    assign w_idle     = (r_state == IDLE);
    // Core wins unless the loader has already been passed over MAX_WAIT times
    assign w_core_win = core_req & (~ldr_req | (w_starve_cnt < L_MAX_WAIT));
    assign w_ldr_win  = ldr_req & (~core_req | (w_starve_cnt == L_MAX_WAIT));
    assign w_tmo_hit  = (w_tmo_cnt == L_TMO_LAST);
    // bus_ready takes precedence over the timeout on the same cycle
    assign w_done     = ~w_idle & (bus_ready | w_tmo_hit);

    // Loader anti-starvation: counts IDLE cycles where the loader lost to the core
    arb_timer #(
        .WIDTH (STARVE_W),
        .LIMIT (L_MAX_WAIT)
    ) u_starve (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (~ldr_req | (w_idle & w_ldr_win)),
        .i_inc (w_idle & ldr_req & w_core_win),
        .o_cnt (w_starve_cnt)
    );

    // Access timeout: counts cycles spent in an access state
    arb_timer #(
        .WIDTH (TMO_W),
        .LIMIT (L_TMO_LIM)
    ) u_tmo (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_idle),
        .i_inc (~w_idle),
        .o_cnt (w_tmo_cnt)
    );

    // Arbitration FSM with registered grant; no preemption once an access starts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_grant <= GNT_NONE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_core_win) begin
                        r_state <= ACC_CORE;
                        r_grant <= state_to_grant(ACC_CORE);
                    end else if (w_ldr_win) begin
                        r_state <= ACC_LDR;
                        r_grant <= state_to_grant(ACC_LDR);
                    end else begin
                        r_state <= IDLE;
                        r_grant <= GNT_NONE;
                    end
                end
                ACC_CORE, ACC_LDR: begin
                    if (w_done) begin
                        r_state <= IDLE;
                        r_grant <= GNT_NONE;
                    end else begin
                        r_state <= r_state;
                        r_grant <= r_grant;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_grant <= GNT_NONE;
                end
            endcase
        end
    end

    // Bus mux and completion responses for the granted master
    always_comb begin
        bus_we     = 1'b0;
        bus_re     = 1'b0;
        bus_addr   = {ADDR_WIDTH{1'b0}};
        bus_wd     = {DATA_WIDTH{1'b0}};
        core_ready = 1'b0;
        core_rd    = {DATA_WIDTH{1'b0}};
        ldr_ready  = 1'b0;
        ldr_rd     = {DATA_WIDTH{1'b0}};
        case (r_state)
            ACC_CORE: begin
                bus_we     = core_we;
                bus_re     = ~core_we;
                bus_addr   = core_addr;
                bus_wd     = core_wd;
                core_ready = w_done;
                if (bus_ready & ~core_we) begin
                    core_rd = bus_rd;
                end else begin
                    core_rd = {DATA_WIDTH{1'b0}};
                end
            end
            ACC_LDR: begin
                bus_we    = ldr_we;
                bus_re    = ~ldr_we;
                bus_addr  = ldr_addr;
                bus_wd    = ldr_wd;
                ldr_ready = w_done;
                if (bus_ready & ~ldr_we) begin
                    ldr_rd = bus_rd;
                end else begin
                    ldr_rd = {DATA_WIDTH{1'b0}};
                end
            end
            default: begin
                bus_we = 1'b0;
            end
        endcase
    end

    assign bus_err    = w_done & ~bus_ready;
    assign core_stall = core_req & ~core_ready;
    assign grant      = r_grant;

endmodule

// File: tb/tb_data_bus_arbiter.sv
module tb_data_bus_arbiter;

    localparam int MAX_WAIT = 4;
    localparam int TIMEOUT  = 15;

    logic        clk;
    logic        rst_n;
    logic        core_req, core_we, ldr_req, ldr_we, bus_ready;
    logic [31:0] core_addr, core_wd, ldr_addr, ldr_wd, bus_rd;
    logic [31:0] core_rd, ldr_rd, bus_addr, bus_wd;
    logic        core_ready, core_stall, ldr_ready, bus_we, bus_re, bus_err;
    logic [1:0]  grant;

    int n_checks = 0;
    int n_errors = 0;

    data_bus_arbiter #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .MAX_WAIT   (MAX_WAIT),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .core_req   (core_req),
        .core_we    (core_we),
        .core_addr  (core_addr),
        .core_wd    (core_wd),
        .core_rd    (core_rd),
        .core_ready (core_ready),
        .core_stall (core_stall),
        .ldr_req    (ldr_req),
        .ldr_we     (ldr_we),
        .ldr_addr   (ldr_addr),
        .ldr_wd     (ldr_wd),
        .ldr_rd     (ldr_rd),
        .ldr_ready  (ldr_ready),
        .bus_we     (bus_we),
        .bus_re     (bus_re),
        .bus_addr   (bus_addr),
        .bus_wd     (bus_wd),
        .bus_rd     (bus_rd),
        .bus_ready  (bus_ready),
        .grant      (grant),
        .bus_err    (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Behavioural reference: who owns the bus, how long it has owned it,
    // and how many arbitrations in a row the loader has lost
    int m_owner;
    int m_elapsed;
    int m_losses;

    task automatic do_reset();
        rst_n = 1'b0;
        core_req = 1'b0; core_we = 1'b0; core_addr = 32'h0; core_wd = 32'h0;
        ldr_req = 1'b0; ldr_we = 1'b0; ldr_addr = 32'h0; ldr_wd = 32'h0;
        bus_ready = 1'b0; bus_rd = 32'h0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_owner = 0; m_elapsed = 0; m_losses = 0;
    endtask

    task automatic model_cycle();
        logic [1:0]  eg;
        logic        ecr, elr, eerr, ewe, ere, mwe, done;
        logic [31:0] ecrd, elrd, eaddr, ewd;
        eg = 2'b00; ecr = 1'b0; elr = 1'b0; eerr = 1'b0; ewe = 1'b0; ere = 1'b0;
        ecrd = 32'h0; elrd = 32'h0; eaddr = 32'h0; ewd = 32'h0; done = 1'b0; mwe = 1'b0;
        if (m_owner != 0) begin
            mwe   = (m_owner == 1) ? core_we : ldr_we;
            eaddr = (m_owner == 1) ? core_addr : ldr_addr;
            ewd   = (m_owner == 1) ? core_wd : ldr_wd;
            ewe   = mwe;
            ere   = !mwe;
            eg    = (m_owner == 1) ? 2'b01 : 2'b10;
            done  = bus_ready || (m_elapsed == TIMEOUT - 1);
            eerr  = done && !bus_ready;
            if (m_owner == 1) begin
                ecr  = done;
                ecrd = (bus_ready && !mwe) ? bus_rd : 32'h0;
            end else begin
                elr  = done;
                elrd = (bus_ready && !mwe) ? bus_rd : 32'h0;
            end
        end
        chk("rnd_grant", 32'(grant), 32'(eg));
        chk("rnd_core_ready", 32'(core_ready), 32'(ecr));
        chk("rnd_ldr_ready", 32'(ldr_ready), 32'(elr));
        chk("rnd_bus_err", 32'(bus_err), 32'(eerr));
        chk("rnd_core_rd", core_rd, ecrd);
        chk("rnd_ldr_rd", ldr_rd, elrd);
        chk("rnd_bus_we", 32'(bus_we), 32'(ewe));
        chk("rnd_bus_re", 32'(bus_re), 32'(ere));
        chk("rnd_bus_addr", bus_addr, eaddr);
        chk("rnd_bus_wd", bus_wd, ewd);
        chk("rnd_core_stall", 32'(core_stall), 32'(core_req && !ecr));
        if (m_owner == 0) begin
            if (core_req && (!ldr_req || m_losses < MAX_WAIT)) begin
                m_owner = 1;
                if (ldr_req && m_losses < MAX_WAIT) m_losses++;
            end else if (ldr_req) begin
                m_owner = 2;
                m_losses = 0;
            end
            m_elapsed = 0;
        end else if (done) begin
            m_owner = 0;
            m_elapsed = 0;
        end else begin
            m_elapsed++;
        end
        if (!ldr_req) m_losses = 0;
    endtask

    // Hold both requests with an instant slave; every (MAX_WAIT+1)th grant is the loader's
    task automatic starve_pattern(input string name, input int ncycles);
        int grants[$];
        for (int c = 0; c < ncycles; c++) begin
            #1;
            if (grant != 2'b00) grants.push_back(int'(grant));
            tick();
        end
        chk({name, "_count"}, 32'(grants.size()), 32'(ncycles / 2));
        for (int k = 0; k < grants.size(); k++) begin
            chk({name, "_grant"}, 32'(grants[k]), (k % (MAX_WAIT + 1) == MAX_WAIT) ? 32'd2 : 32'd1);
        end
    endtask

    typedef struct {
        logic        c_req, c_we, l_req, l_we, b_rdy;
        logic [31:0] b_rd;
        logic [1:0]  e_grant;
        logic        e_cr, e_lr, e_err, e_stall, e_we, e_re;
        logic [31:0] e_crd, e_lrd;
    } vec_t;

    function automatic vec_t mk(input logic c_req, c_we, l_req, l_we, b_rdy,
                                input logic [31:0] b_rd, input logic [1:0] e_grant,
                                input logic e_cr, e_lr, e_err, e_stall, e_we, e_re,
                                input logic [31:0] e_crd, e_lrd);
        vec_t v;
        v.c_req = c_req; v.c_we = c_we; v.l_req = l_req; v.l_we = l_we; v.b_rdy = b_rdy;
        v.b_rd = b_rd; v.e_grant = e_grant; v.e_cr = e_cr; v.e_lr = e_lr; v.e_err = e_err;
        v.e_stall = e_stall; v.e_we = e_we; v.e_re = e_re; v.e_crd = e_crd; v.e_lrd = e_lrd;
        return v;
    endfunction

    vec_t vecs[8];

    initial begin
        //            creq cwe lreq lwe rdy  bus_rd        gnt   cr lr er st we re  core_rd       ldr_rd
        vecs[0] = mk(1'b1,1'b0,1'b0,1'b0,1'b1,32'hCAFE_0001,2'b00,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,32'h0,32'h0);
        vecs[1] = mk(1'b1,1'b0,1'b0,1'b0,1'b1,32'hCAFE_0001,2'b01,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,32'hCAFE_0001,32'h0);
        vecs[2] = mk(1'b0,1'b0,1'b0,1'b0,1'b1,32'hCAFE_0001,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,32'h0);
        vecs[3] = mk(1'b0,1'b0,1'b1,1'b1,1'b1,32'hCAFE_0001,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,32'h0);
        vecs[4] = mk(1'b0,1'b0,1'b1,1'b1,1'b1,32'hCAFE_0001,2'b10,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,32'h0,32'h0);
        vecs[5] = mk(1'b0,1'b0,1'b0,1'b0,1'b1,32'h1111_2222,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,32'h0);
        vecs[6] = mk(1'b0,1'b0,1'b1,1'b0,1'b1,32'h5A5A_0000,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,32'h0);
        vecs[7] = mk(1'b0,1'b0,1'b1,1'b0,1'b1,32'h5A5A_0000,2'b10,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,32'h0,32'h5A5A_0000);

        // Reset state: outputs idle, stall follows core_req
        rst_n = 1'b0;
        core_req = 1'b1; core_we = 1'b0; core_addr = 32'h0; core_wd = 32'h0;
        ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 32'h0; ldr_wd = 32'h0;
        bus_ready = 1'b1; bus_rd = 32'hFFFF_FFFF;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_core_ready", 32'(core_ready), 32'h0);
        chk("rst_ldr_ready", 32'(ldr_ready), 32'h0);
        chk("rst_bus_re", 32'(bus_re), 32'h0);
        chk("rst_bus_err", 32'(bus_err), 32'h0);
        chk("rst_core_stall", 32'(core_stall), 32'h1);

        // Table-driven basic transfers (core read, loader write, loader read, ready in IDLE)
        do_reset();
        core_addr = 32'h1000_0004; ldr_addr = 32'h0000_0010; ldr_wd = 32'h0BAD_0BAD;
        for (int i = 0; i < 8; i++) begin
            core_req = vecs[i].c_req; core_we = vecs[i].c_we;
            ldr_req = vecs[i].l_req; ldr_we = vecs[i].l_we;
            bus_ready = vecs[i].b_rdy; bus_rd = vecs[i].b_rd;
            #1;
            chk("vec_grant", 32'(grant), 32'(vecs[i].e_grant));
            chk("vec_core_ready", 32'(core_ready), 32'(vecs[i].e_cr));
            chk("vec_ldr_ready", 32'(ldr_ready), 32'(vecs[i].e_lr));
            chk("vec_bus_err", 32'(bus_err), 32'(vecs[i].e_err));
            chk("vec_core_stall", 32'(core_stall), 32'(vecs[i].e_stall));
            chk("vec_bus_we", 32'(bus_we), 32'(vecs[i].e_we));
            chk("vec_bus_re", 32'(bus_re), 32'(vecs[i].e_re));
            chk("vec_core_rd", core_rd, vecs[i].e_crd);
            chk("vec_ldr_rd", ldr_rd, vecs[i].e_lrd);
            tick();
        end

        // Anti-starvation with both requests held
        do_reset();
        core_req = 1'b1; ldr_req = 1'b1; bus_ready = 1'b1; bus_rd = 32'h7777_0000;
        starve_pattern("starve", 20);

        // Loader write with three wait states
        do_reset();
        ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 32'h0000_0010; ldr_wd = 32'h1234_5678;
        #1;
        chk("ws_idle_we", 32'(bus_we), 32'h0);
        tick();
        for (int k = 1; k <= 4; k++) begin
            bus_ready = (k == 4);
            #1;
            chk("ws_bus_we", 32'(bus_we), 32'h1);
            chk("ws_bus_wd", bus_wd, 32'h1234_5678);
            chk("ws_bus_addr", bus_addr, 32'h0000_0010);
            chk("ws_ldr_ready", 32'(ldr_ready), 32'(k == 4));
            chk("ws_bus_err", 32'(bus_err), 32'h0);
            tick();
        end
        ldr_req = 1'b0; bus_ready = 1'b0;
        #1;
        chk("ws_after_we", 32'(bus_we), 32'h0);
        chk("ws_after_grant", 32'(grant), 32'h0);

        // Timeout on a core read with a pending loader request
        do_reset();
        core_req = 1'b1; core_we = 1'b0; core_addr = 32'h2000_0000;
        ldr_req = 1'b1; ldr_we = 1'b1; bus_rd = 32'hDEAD_BEEF;
        #1;
        chk("tmo_c0_stall", 32'(core_stall), 32'h1);
        tick();
        for (int k = 1; k <= TIMEOUT; k++) begin
            #1;
            chk("tmo_grant", 32'(grant), 32'h1);
            chk("tmo_core_ready", 32'(core_ready), 32'(k == TIMEOUT));
            chk("tmo_bus_err", 32'(bus_err), 32'(k == TIMEOUT));
            if (k == TIMEOUT) chk("tmo_core_rd", core_rd, 32'h0);
            tick();
        end
        core_req = 1'b0;
        #1;
        chk("tmo_idle_grant", 32'(grant), 32'h0);
        chk("tmo_idle_err", 32'(bus_err), 32'h0);
        tick();
        #1;
        chk("tmo_ldr_grant", 32'(grant), 32'h2);

        // Ready arriving on the timeout cycle wins over the abort
        do_reset();
        core_req = 1'b1; core_we = 1'b0; bus_rd = 32'h0BAD_F00D;
        tick();
        for (int k = 1; k <= TIMEOUT; k++) begin
            bus_ready = (k == TIMEOUT);
            #1;
            chk("edge_bus_err", 32'(bus_err), 32'h0);
            chk("edge_core_ready", 32'(core_ready), 32'(k == TIMEOUT));
            if (k == TIMEOUT) chk("edge_core_rd", core_rd, 32'h0BAD_F00D);
            tick();
        end
        core_req = 1'b0; bus_ready = 1'b1;
        #1;
        chk("edge_idle_ready", 32'(core_ready), 32'h0);
        chk("edge_idle_err", 32'(bus_err), 32'h0);

        // Reset in the middle of a loader read
        do_reset();
        ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 32'h0000_0040;
        tick();
        #1;
        chk("mrst_pre_grant", 32'(grant), 32'h2);
        chk("mrst_pre_re", 32'(bus_re), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_re", 32'(bus_re), 32'h0);
        chk("mrst_grant", 32'(grant), 32'h0);
        chk("mrst_ldr_ready", 32'(ldr_ready), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        m_owner = 0; m_elapsed = 0; m_losses = 0;
        core_req = 1'b1; bus_ready = 1'b1;
        starve_pattern("mrst_starve", 10);

        // Randomized traffic against the reference model
        do_reset();
        for (int c = 0; c < 1200; c++) begin
            int slow;
            slow = ((c / 60) % 2);
            core_req  = ($urandom_range(0, 3) != 0);
            ldr_req   = ($urandom_range(0, 3) != 0);
            core_we   = $urandom_range(0, 1);
            ldr_we    = $urandom_range(0, 1);
            core_addr = $urandom; core_wd = $urandom;
            ldr_addr  = $urandom; ldr_wd  = $urandom;
            bus_rd    = $urandom;
            bus_ready = (slow != 0) ? ($urandom_range(0, 31) == 0) : ($urandom_range(0, 2) != 0);
            #1;
            model_cycle();
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
